// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - RV32I field packer with sequential word addresses and a 2-entry output buffer
// Optional immediate range checking is enabled by defining IMM_CHECK_EN.
module instruction_encoder #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            fmt,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [2:0]            func3,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [6:0]            func7,
    input  logic [31:0]           imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [15:0]           enc_count,
    output logic                  fmt_err,
    output logic                  imm_err
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [31:0]           NOP  = 32'h0000_0013;

    logic [31:0]           enc_word;
    logic                  fmt_bad;
    logic [31:0]           head_instr, tail_instr;
    logic [ADDR_WIDTH-1:0] head_addr, tail_addr, next_addr;
    logic [1:0]            occ;
    logic                  accept, pop;

    always_comb begin
        enc_word = NOP;
        fmt_bad  = 1'b0;
        case (fmt)
            3'd0: enc_word = {func7, rs2, rs1, func3, rd, opcode};
            3'd1: enc_word = {imm[11:0], rs1, func3, rd, opcode};
            3'd2: enc_word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
            3'd3: enc_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
            3'd4: enc_word = {imm[31:12], rd, opcode};
            3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: begin
                enc_word = NOP;
                fmt_bad  = 1'b1;
            end
        endcase
    end

    // Handshake flags come only from registered occupancy, so out_ready never reaches in_ready.
    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign instr     = head_instr;
    assign out_addr  = head_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ        <= 2'd0;
            head_instr <= 32'd0;
            head_addr  <= BASE;
            tail_instr <= 32'd0;
            tail_addr  <= BASE;
            next_addr  <= BASE;
            enc_count  <= 16'd0;
            fmt_err    <= 1'b0;
        end else if (clear) begin
            occ        <= 2'd0;
            head_instr <= 32'd0;
            head_addr  <= BASE;
            next_addr  <= BASE;
            enc_count  <= 16'd0;
            fmt_err    <= 1'b0;
        end else begin
            case ({accept, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_instr <= enc_word;
                        head_addr  <= next_addr;
                    end else begin
                        tail_instr <= enc_word;
                        tail_addr  <= next_addr;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_instr <= tail_instr;
                    head_addr  <= tail_addr;
                    occ        <= occ - 2'd1;
                end
                // Accept with pop only happens at occupancy 1: the new word replaces the head.
                2'b11: begin
                    head_instr <= enc_word;
                    head_addr  <= next_addr;
                end
                default: ;
            endcase
            if (accept) begin
                next_addr <= next_addr + 1'b1;
                if (enc_count != 16'hFFFF) enc_count <= enc_count + 16'd1;
                if (fmt_bad) fmt_err <= 1'b1;
            end
        end
    end

`ifdef IMM_CHECK_EN
    logic imm_bad;

    always_comb begin
        imm_bad = 1'b0;
        case (fmt)
            3'd1, 3'd2: imm_bad = (imm != {{20{imm[11]}}, imm[11:0]});
            3'd3:       imm_bad = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
            3'd4:       imm_bad = (imm[11:0] != 12'd0);
            3'd5:       imm_bad = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
            default:    imm_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     imm_err <= 1'b0;
        else if (clear)              imm_err <= 1'b0;
        else if (accept && imm_bad)  imm_err <= 1'b1;
    end
`else
    assign imm_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - table, sequence and random checks of instruction_encoder against a queue model
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, out_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode, func7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3;
    logic [31:0] imm;
    logic        in_ready, out_valid, fmt_err, imm_err;
    logic [31:0] instr;
    logic [9:0]  out_addr;
    logic [15:0] enc_count;

    logic        v2, rdy2, ir2, ov2, fe2, ie2;
    logic [31:0] instr2;
    logic [1:0]  addr2;
    logic [15:0] cnt2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] instr;
        int          addr;
    } entry_t;
    entry_t q[$];
    int m_addr, m_count;
    bit m_ferr, m_ierr;

    typedef struct {
        logic [2:0]  f;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[7];

    instruction_encoder #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2),
        .func7(func7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .out_addr(out_addr), .enc_count(enc_count),
        .fmt_err(fmt_err), .imm_err(imm_err)
    );

    instruction_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(1)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(v2), .in_ready(ir2),
        .fmt(fmt), .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2),
        .func7(func7), .imm(imm), .out_valid(ov2), .out_ready(rdy2),
        .instr(instr2), .out_addr(addr2), .enc_count(cnt2),
        .fmt_err(fe2), .imm_err(ie2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] op, d, f3, r1, r2, f7, im;
        op = 32'(opcode); d = 32'(rd); f3 = 32'(func3); r1 = 32'(rs1);
        r2 = 32'(rs2); f7 = 32'(func7); im = imm;
        case (fmt)
            3'd0: return op + (d << 7) + (f3 << 12) + (r1 << 15) + (r2 << 20) + (f7 << 25);
            3'd1: return op + (d << 7) + (f3 << 12) + (r1 << 15) + ((im & 32'hFFF) << 20);
            3'd2: return op + ((im & 31) << 7) + (f3 << 12) + (r1 << 15) + (r2 << 20)
                         + (((im >> 5) & 127) << 25);
            3'd3: return op + (((im >> 11) & 1) << 7) + (((im >> 1) & 15) << 8) + (f3 << 12)
                         + (r1 << 15) + (r2 << 20) + (((im >> 5) & 63) << 25)
                         + (((im >> 12) & 1) << 31);
            3'd4: return op + (d << 7) + (im & 32'hFFFF_F000);
            3'd5: return op + (d << 7) + (((im >> 12) & 255) << 12) + (((im >> 11) & 1) << 20)
                         + (((im >> 1) & 1023) << 21) + (((im >> 20) & 1) << 31);
            default: return 32'h13;
        endcase
    endfunction

    function automatic bit model_imm_bad();
`ifdef IMM_CHECK_EN
        longint s;
        s = longint'($signed(imm));
        case (fmt)
            3'd1, 3'd2: return (s < -2048) || (s > 2047);
            3'd3:       return (s < -4096) || (s > 4095) || (imm % 2 != 0);
            3'd4:       return (imm % 4096) != 0;
            3'd5:       return (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 1) || (imm % 2 != 0);
            default:    return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    // Check the visible state, advance one clock, then update the model.
    task automatic step();
        bit acc, pp;
        logic [31:0] w;
        chk("in_ready", 32'(in_ready), 32'(q.size() != 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("instr", instr, q[0].instr);
            chk("out_addr", 32'(out_addr), 32'(q[0].addr));
        end
        chk("enc_count", 32'(enc_count), 32'(m_count));
        chk("fmt_err", 32'(fmt_err), 32'(m_ferr));
        chk("imm_err", 32'(imm_err), 32'(m_ierr));
        acc = !clear && in_valid && (q.size() < 2);
        pp  = !clear && out_ready && (q.size() > 0);
        w   = model_word();
        @(posedge clk);
        #1;
        if (clear) begin
            q.delete();
            m_addr = 0; m_count = 0; m_ferr = 0; m_ierr = 0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back('{w, m_addr});
                m_addr = (m_addr + 1) % 1024;
                if (m_count < 65535) m_count++;
                if (fmt > 3'd5) m_ferr = 1;
                if (model_imm_bad()) m_ierr = 1;
            end
        end
    endtask

    task automatic load(input vec_t v);
        fmt = v.f; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        func3 = v.f3; func7 = v.f7; imm = v.imm;
    endtask

    initial begin
        int exp2[5];
        tbl[0] = '{3'd0, 7'h33, 5'd11, 5'd11, 5'd12, 3'd0, 7'd0, 32'd0, 32'h00C585B3};
        tbl[1] = '{3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00108093};
        tbl[2] = '{3'd2, 7'h23, 5'd0, 5'd2, 5'd11, 3'd2, 7'd0, 32'd4, 32'h00B12223};
        tbl[3] = '{3'd3, 7'h63, 5'd0, 5'd10, 5'd11, 3'd0, 7'd0, 32'd12, 32'h00B50663};
        tbl[4] = '{3'd4, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000B000, 32'h0000B537};
        tbl[5] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 32'h004000EF};
        tbl[6] = '{3'd7, 7'h33, 5'd5, 5'd6, 5'd7, 3'd1, 7'h20, 32'hFFFFFFFF, 32'h00000013};
        exp2 = '{1, 2, 3, 0, 1};

        rst = 1; clear = 0; in_valid = 0; out_ready = 0; v2 = 0; rdy2 = 0;
        load(tbl[0]);
        m_addr = 0; m_count = 0; m_ferr = 0; m_ierr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst instr", instr, 32'd0);
        chk("rst out_addr", 32'(out_addr), 32'd0);
        chk("rst enc_count", 32'(enc_count), 32'd0);
        rst = 0;

        // Back-to-back table words
        out_ready = 1;
        for (int i = 0; i < 7; i++) begin
            load(tbl[i]);
            in_valid = 1;
            step();
            chk($sformatf("tbl%0d instr", i), instr, tbl[i].exp);
            chk($sformatf("tbl%0d addr", i), 32'(out_addr), i);
        end
        in_valid = 0;
        step();
        chk("tbl enc_count", 32'(enc_count), 32'd7);
        chk("tbl fmt_err", 32'(fmt_err), 32'd1);
        step();
        chk("fmt_err sticky", 32'(fmt_err), 32'd1);

        // Backpressure
        clear = 1; step(); clear = 0;
        chk("clear fmt_err", 32'(fmt_err), 32'd0);
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            load(tbl[i]);
            step();
        end
        chk("bp in_ready", 32'(in_ready), 32'd0);
        chk("bp instr hold", instr, tbl[0].exp);
        out_ready = 1;
        repeat (2) step();
        in_valid = 0;
        repeat (4) step();
        chk("bp count", 32'(enc_count), 32'd3);

        // Immediate range
        clear = 1; step(); clear = 0;
        fmt = 3'd1; opcode = 7'h13; imm = 32'hFFFFF800; in_valid = 1;
        step();
        chk("imm I ok", 32'(imm_err), 32'd0);
        fmt = 3'd3; opcode = 7'h63; imm = 32'd13;
        step();
`ifdef IMM_CHECK_EN
        chk("imm B odd", 32'(imm_err), 32'd1);
`else
        chk("imm B odd", 32'(imm_err), 32'd0);
`endif
        in_valid = 0;
        step();

        // Clear while full with a pending request
        out_ready = 0; in_valid = 1;
        repeat (3) step();
        clear = 1;
        step();
        clear = 0; in_valid = 0;
        chk("clr out_valid", 32'(out_valid), 32'd0);
        chk("clr out_addr", 32'(out_addr), 32'd0);
        chk("clr enc_count", 32'(enc_count), 32'd0);
        chk("clr in_ready", 32'(in_ready), 32'd1);
        step();
        chk("clr not stored", 32'(out_valid), 32'd0);

        // Address wrap on the 2-bit instance (base 1)
        clear = 1; step(); clear = 0;
        v2 = 1; rdy2 = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wrap valid", 32'(ov2), 32'd1);
            chk($sformatf("wrap addr%0d", i), 32'(addr2), 32'(exp2[i]));
        end
        v2 = 0; rdy2 = 0;
        step();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            clear     = ($urandom % 60) == 0;
            fmt = 3'($urandom); opcode = 7'($urandom); rd = 5'($urandom);
            rs1 = 5'($urandom); rs2 = 5'($urandom); func3 = 3'($urandom);
            func7 = 7'($urandom);
            case ($urandom % 3)
                0:       imm = $urandom;
                1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            step();
        end
        clear = 0;

        // Asynchronous reset with words buffered
        out_ready = 0; in_valid = 1;
        repeat (2) step();
        in_valid = 0;
        #2 rst = 1;
        #1;
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst in_ready", 32'(in_ready), 32'd1);
        chk("arst instr", instr, 32'd0);
        chk("arst enc_count", 32'(enc_count), 32'd0);
        q.delete();
        m_addr = 0; m_count = 0; m_ferr = 0; m_ierr = 0;
        #2 rst = 0;
        @(posedge clk);
        #1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
Inverse of the instruction decoder: packs RV32I fields (opcode, rd, func3, rs1, rs2, func7, immediate) into 32-bit instruction words for a selected format (R/I/S/B/U/J). It sits between the program-loader/self-test sequencer and instruction memory. Each encoded word leaves with a sequential word address. Input and output use valid/ready handshakes, with a 2-entry output buffer between them.

Parameters:
ADDR_WIDTH, 10, width of the word-address counter (addresses 0..2^ADDR_WIDTH-1).
BASE_ADDR, 0, word address loaded on reset and on clear.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
clear  in  1  synchronous flush: empty buffer, address := BASE_ADDR, count := 0, errors cleared
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 invalid
opcode  in  7  opcode field
rd  in  5  destination register
func3  in  3  func3 field
rs1  in  5  source register 1
rs2  in  5  source register 2
func7  in  7  func7 field (R only)
imm  in  32  immediate, byte offset; U takes imm[31:12]
out_valid  out  1  encoded word available
out_ready  in  1  consumer accepts when out_valid && out_ready
instr  out  32  encoded instruction (buffer head)
out_addr  out  ADDR_WIDTH  word address of instr
enc_count  out  16  total words accepted since reset/clear, saturating at 0xFFFF
fmt_err  out  1  sticky: invalid fmt accepted
imm_err  out  1  sticky: immediate out of range (see Optional Feature)

Behaviour:
- Reset (async): buffer empty, out_valid=0, in_ready=1, instr=0, out_addr=BASE_ADDR, enc_count=0, fmt_err=0, imm_err=0.
- Encoding (MSB..LSB):
  R = func7|rs2|rs1|func3|rd|opcode
  I = imm[11:0]|rs1|func3|rd|opcode
  S = imm[11:5]|rs2|rs1|func3|imm[4:0]|opcode
  B = imm[12]|imm[10:5]|rs2|rs1|func3|imm[4:1]|imm[11]|opcode
  U = imm[31:12]|rd|opcode
  J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Field masking: unused fields are ignored; imm bits outside the format's field are dropped.
- Invalid fmt (6/7): word 0x00000013 (NOP) is still emitted and consumes an address; fmt_err sets.
- Buffer: 2-entry FIFO of {instr, addr}. in_ready = (occupancy != 2), from registered state only; no combinational path from out_ready.
- Latency: a word accepted in cycle N is at the head with out_valid=1 in cycle N+1 if the buffer was empty.
- Simultaneous push and pop:
  - occupancy 1: occupancy stays 1, head advances.
  - occupancy 2: no push (in_ready=0), pop only.
- Address: stamped at accept time, then increments by 1. Wraps from 2^ADDR_WIDTH-1 to 0, not to BASE_ADDR. No error on wrap.
- enc_count: increments on every accept.
- Output stability: instr and out_addr hold while out_valid && !out_ready.
- clear: has priority over a same-cycle accept or pop. That request is discarded; in_ready is 1 the following cycle.
- Reset mid-operation: buffered words are lost, no partial output.

Optional Feature:
IMM_CHECK_EN
- Defined: range-checks the immediate on accept.
  - I/S: imm must equal sign-extension of imm[11:0].
  - B: 13-bit signed and imm[0]=0.
  - J: 21-bit signed and imm[0]=0.
  - U: imm[11:0]=0.
  - R: no check.
  - A violation sets imm_err (sticky). The word is still encoded with truncated fields.
- Undefined: imm_err is tied to 0; no check logic.

Test Plan:
- Reset, then encode six words back-to-back with out_ready=1 -> instr/out_addr pairs, one per cycle from cycle 1:
  - R opcode=0x33 rd=11 rs1=11 rs2=12 func3=0 func7=0 -> 0x00C585B3 @0
  - I opcode=0x13 rd=1 rs1=1 imm=1 -> 0x00108093 @1
  - S opcode=0x23 func3=2 rs1=2 rs2=11 imm=4 -> 0x00B12223 @2
  - B opcode=0x63 func3=0 rs1=10 rs2=11 imm=12 -> 0x00B50663 @3
  - U opcode=0x37 rd=10 imm=0x0000B000 -> 0x0000B537 @4
  - J opcode=0x6F rd=1 imm=4 -> 0x004000EF @5
  - enc_count=6.
- Backpressure: out_ready=0, in_valid=1 -> two accepts, then in_ready=0. instr holds 0x00C585B3. Release -> order preserved, no loss or duplicate.
- fmt=7 -> instr=0x00000013, fmt_err=1 and stays 1 until clear.
- With ADDR_WIDTH=2, push 5 words -> out_addr 0,1,2,3,0.
- With IMM_CHECK_EN: B imm=13 -> imm_err=1; I imm=0xFFFFF800 -> no error. Without IMM_CHECK_EN: imm_err=0 in both cases.
- clear while occupancy=2 and in_valid=1 -> next cycle out_valid=0, out_addr=BASE_ADDR, enc_count=0; the clear-cycle request is not stored.
